// File: rtl/change_dispenser.sv
// Change dispenser: latches cash and ticket category, computes change and
// pays it out one coin per handshake, always choosing the largest available
// denomination from a per-denomination inventory.
module change_dispenser #(
  parameter int                       CASH_W    = 8,
  parameter int                       NCAT      = 3,
  parameter int                       CAT_W     = 2,
  parameter logic [NCAT*CASH_W-1:0]   PRICE_VEC = {8'd15, 8'd12, 8'd8},
  parameter int                       D0        = 10,
  parameter int                       D1        = 5,
  parameter int                       D2        = 2,
  parameter int                       D3        = 1,
  parameter int                       INV_W     = 4,
  parameter int                       INV_INIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cancel,
  input  logic [CAT_W-1:0]  cat_sel,
  input  logic [CASH_W-1:0] cash,
  output logic              coin_valid,
  output logic [1:0]        coin_idx,
  input  logic              coin_ready,
  output logic              busy,
  output logic              done,
  output logic              shortfall,
  output logic [CASH_W-1:0] short_amt,
  output logic              insufficient,
  input  logic              refill,
  input  logic [1:0]        refill_idx,
  input  logic [INV_W-1:0]  refill_cnt
);

  // Denomination values, index 0 is the largest coin.
  localparam logic [CASH_W-1:0] DEN [4] = '{CASH_W'(D0), CASH_W'(D1), CASH_W'(D2), CASH_W'(D3)};
  localparam logic [INV_W-1:0]  INV_RST = INV_W'(INV_INIT);
  localparam logic [INV_W-1:0]  INV_ONE = INV_W'(1);
  localparam logic [INV_W-1:0]  INV_ZERO = INV_W'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DISP  = 2'd1,
    DONE  = 2'd2,
    SHORT = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [CASH_W-1:0]   remaining_r;
  logic [CASH_W-1:0]   short_amt_r;
  logic                insufficient_r;
  logic [INV_W-1:0]    inv_r [4];

  logic [CASH_W-1:0]   price_s;
  logic [CASH_W-1:0]   start_rem_s;
  logic                start_insuff_s;
  logic                sel_found_s;
  logic [1:0]          sel_idx_s;
  logic [CASH_W-1:0]   next_rem_s;

  // Price lookup; categories outside the table cost nothing, so all cash is refunded.
  always_comb begin
    price_s = '0;
    for (int k = 0; k < NCAT; k++) begin
      if (cat_sel == CAT_W'(k)) begin
        price_s = PRICE_VEC[k*CASH_W +: CASH_W];
      end else begin
        price_s = price_s;
      end
    end
  end

  // Change owed at start: full cash on cancel or underpayment, else cash minus price.
  always_comb begin
    start_rem_s    = cash;
    start_insuff_s = 1'b0;
    if (cancel) begin
      start_rem_s    = cash;
      start_insuff_s = 1'b0;
    end else if (cash < price_s) begin
      start_rem_s    = cash;
      start_insuff_s = 1'b1;
    end else begin
      start_rem_s    = cash - price_s;
      start_insuff_s = 1'b0;
    end
  end

  // Largest coin that fits the remainder and is still in stock (lowest index wins).
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((DEN[i] <= remaining_r) && (inv_r[i] != INV_ZERO)) begin
        sel_found_s = 1'b1;
        sel_idx_s   = 2'(i);
      end else begin
        sel_found_s = sel_found_s;
        sel_idx_s   = sel_idx_s;
      end
    end
  end

  assign next_rem_s = remaining_r - DEN[sel_idx_s];

  // Next-state logic of the dispense sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = (start_rem_s != '0) ? DISP : DONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DISP: begin
        if (!sel_found_s) begin
          state_nx_s = SHORT;
        end else if (coin_ready && (next_rem_s == '0)) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = DISP;
        end
      end
      DONE:    state_nx_s = IDLE;
      SHORT:   state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Transaction datapath and coin inventory; inventory only changes in IDLE
  // (refill) or on a coin handshake, so an offered coin never shifts under the actuator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_r    <= '0;
      short_amt_r    <= '0;
      insufficient_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        inv_r[i] <= INV_RST;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            remaining_r    <= start_rem_s;
            insufficient_r <= start_insuff_s;
            short_amt_r    <= '0;
          end
          if (refill) begin
            inv_r[refill_idx] <= refill_cnt;
          end
        end
        DISP: begin
          if (sel_found_s) begin
            if (coin_ready) begin
              remaining_r        <= next_rem_s;
              inv_r[sel_idx_s]   <= inv_r[sel_idx_s] - INV_ONE;
            end
          end else begin
            short_amt_r <= remaining_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign coin_valid   = (state_r == DISP) && sel_found_s;
  assign coin_idx     = (state_r == DISP) ? sel_idx_s : 2'd0;
  assign busy         = (state_r != IDLE);
  assign done         = (state_r == DONE);
  assign shortfall    = (state_r == SHORT);
  assign short_amt    = short_amt_r;
  assign insufficient = insufficient_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table of transactions plus
// hand-written sequences; coin order is checked through a scoreboard queue.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cancel;
  logic [1:0] cat_sel;
  logic [7:0] cash;
  logic       coin_valid;
  logic [1:0] coin_idx;
  logic       coin_ready;
  logic       busy, done, shortfall;
  logic [7:0] short_amt;
  logic       insufficient;
  logic       refill;
  logic [1:0] refill_idx;
  logic [3:0] refill_cnt;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  logic [1:0] exp_q [$];

  typedef struct packed {
    logic            cancel;
    logic [1:0]      cat;
    logic [7:0]      cash;
    logic [3:0]      stall;
    logic [2:0]      n;
    logic [3:0][1:0] coins;     // coins[0] is paid first
    logic            short_end;
    logic [7:0]      short_amt;
    logic            insuff;
    logic [3:0][3:0] inv;       // inventory after the transaction, inv[i] = counter i
  } vec_t;

  vec_t vecs [6];

  change_dispenser dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .cat_sel(cat_sel),
    .cash(cash), .coin_valid(coin_valid), .coin_idx(coin_idx), .coin_ready(coin_ready),
    .busy(busy), .done(done), .shortfall(shortfall), .short_amt(short_amt),
    .insufficient(insufficient), .refill(refill), .refill_idx(refill_idx),
    .refill_cnt(refill_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: every handshake pops the expected coin index.
  always @(negedge clk) begin
    if (!rst && coin_valid && coin_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_coin: got idx %0d with empty scoreboard (t=%0t)", coin_idx, $time);
      end else begin
        chk("coin_idx", 32'(coin_idx), 32'(exp_q.pop_front()));
        last_hs_cyc = cyc;
      end
    end
  end

  function automatic logic [31:0] inv_now();
    return 32'({dut.inv_r[3], dut.inv_r[2], dut.inv_r[1], dut.inv_r[0]});
  endfunction

  // Called at a negedge; returns at the negedge where done or shortfall is seen.
  task automatic wait_end(output bit ended);
    ended = 1'b0;
    for (int c = 0; c < 20 && !ended; c++) begin
      if (done || shortfall) ended = 1'b1;
      else @(negedge clk);
    end
    chk("end_seen", 32'(ended), 32'd1);
  endtask

  task automatic load_inv(input logic [1:0] idx, input logic [3:0] cnt);
    @(posedge clk); #1;
    refill = 1'b1; refill_idx = idx; refill_cnt = cnt;
    @(posedge clk); #1;
    refill = 1'b0;
  endtask

  task automatic run_txn(input int k);
    vec_t v;
    bit   ended;
    v = vecs[k];
    for (int j = 0; j < int'(v.n); j++) exp_q.push_back(v.coins[j]);
    @(posedge clk); #1;
    start = 1'b1; cancel = v.cancel; cat_sel = v.cat; cash = v.cash;
    coin_ready = (v.stall == 4'd0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("first_valid", 32'(coin_valid), 32'(v.n != 3'd0));
    chk("insufficient", 32'(insufficient), 32'(v.insuff));
    for (int s = 0; s < int'(v.stall); s++) begin
      chk("stall_hold", 32'({coin_valid, coin_idx}), 32'({1'b1, v.coins[0]}));
      @(posedge clk); #1;
      if (s == int'(v.stall) - 1) coin_ready = 1'b1;
      @(negedge clk);
    end
    wait_end(ended);
    if (ended) begin
      chk("end_kind", 32'({done, shortfall}), 32'({~v.short_end, v.short_end}));
      chk("short_amt", 32'(short_amt), 32'(v.short_amt));
      if (v.n != 3'd0 && !v.short_end) chk("done_latency", 32'(cyc - last_hs_cyc), 32'd1);
    end
    chk("coins_left", 32'(exp_q.size()), 32'd0);
    chk("inventory", inv_now(), 32'(v.inv));
    @(negedge clk);
    chk("pulse_one_cycle", 32'({done, shortfall, busy}), 32'd0);
    chk("short_amt_hold", 32'(short_amt), 32'(v.short_amt));
    coin_ready = 1'b0;
  endtask

  initial begin
    bit ended;
    //                 cancel cat   cash   stall n     coins  short  amt    insuf inv{3,2,1,0}
    vecs[0] = {1'b0, 2'd1, 8'd30, 4'd3, 3'd4, 8'he4, 1'b0, 8'd0, 1'b0, 16'h3333};
    vecs[1] = {1'b0, 2'd2, 8'd10, 4'd0, 3'd1, 8'h00, 1'b0, 8'd0, 1'b1, 16'h3332};
    vecs[2] = {1'b1, 2'd0, 8'd7,  4'd0, 3'd2, 8'h09, 1'b0, 8'd0, 1'b0, 16'h3222};
    vecs[3] = {1'b0, 2'd0, 8'd11, 4'd0, 3'd1, 8'h03, 1'b1, 8'd2, 1'b0, 16'h0022};
    vecs[4] = {1'b0, 2'd0, 8'd8,  4'd0, 3'd0, 8'h00, 1'b0, 8'd0, 1'b0, 16'h0022};
    vecs[5] = {1'b0, 2'd3, 8'd6,  4'd1, 3'd2, 8'h0d, 1'b0, 8'd0, 1'b0, 16'h3434};

    rst = 1'b1; start = 1'b0; cancel = 1'b0; cat_sel = 2'd0; cash = 8'd0;
    coin_ready = 1'b0; refill = 1'b0; refill_idx = 2'd0; refill_cnt = 4'd0;
    #12;
    chk("reset_outputs", 32'({coin_valid, coin_idx, busy, done, shortfall, insufficient}), 32'd0);
    chk("reset_short_amt", 32'(short_amt), 32'd0);
    chk("reset_inventory", inv_now(), 32'h4444);
    @(posedge clk); #1;
    rst = 1'b0;

    // Change with stall, underpayment, cancel.
    for (int k = 0; k < 3; k++) run_txn(k);

    // Exhaustion: drain denominations 2 and 3, one load per cycle.
    load_inv(2'd2, 4'd0);
    load_inv(2'd3, 4'd1);
    @(negedge clk);
    chk("refill_loaded", inv_now(), 32'h1022);
    run_txn(3);

    // Exact payment: no coins, straight to done; clears held short_amt.
    run_txn(4);

    // Restock, then out-of-range category refunds full cash.
    for (int i = 0; i < 4; i++) load_inv(2'(i), 4'd4);
    run_txn(5);

    // Refill and start during DISP are ignored.
    for (int j = 0; j < 4; j++) exp_q.push_back(2'(j));
    @(posedge clk); #1;
    start = 1'b1; cat_sel = 2'd1; cash = 8'd30; coin_ready = 1'b0;
    @(posedge clk); #1;
    refill = 1'b1; refill_idx = 2'd0; refill_cnt = 4'd9;
    start = 1'b1; cancel = 1'b1; cat_sel = 2'd2; cash = 8'd99;
    @(posedge clk); #1;
    @(posedge clk); #1;
    refill = 1'b0; start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("blocked_refill", inv_now(), 32'h3434);
    chk("offer_held", 32'({busy, coin_valid, coin_idx}), 32'({1'b1, 1'b1, 2'd0}));
    coin_ready = 1'b1;
    wait_end(ended);
    chk("blocked_done", 32'(done), 32'd1);
    chk("blocked_inv_after", inv_now(), 32'h2323);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_restart", 32'(busy), 32'd0);
    end
    coin_ready = 1'b0;

    // Reset after one handshake.
    exp_q.push_back(2'd0);
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b0; cat_sel = 2'd1; cash = 8'd30; coin_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 32'({coin_valid, busy}), 32'd0);
    chk("rst_mid_inv", inv_now(), 32'h4444);
    chk("rst_mid_scoreboard", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; coin_ready = 1'b0;
    run_txn(0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, checks);
    $fatal(1);
  end

endmodule
